bidir_pio_ctrl: RTL
===================

// Module: bidir_pio_ctrl
// PURPOSE
//  Parametrised Avalon-MM bidirectional PIO: WIDTH pins, per-bit direction, push-pull or open-drain drive.
//  Synchronised input sampling, per-bit edge capture with maskable level IRQ.
//  Sits between the Nios II data master and board GPIO/I2C/LCD-control pins.
//  In open-drain mode it serves bit-banged I2C SDA/SCL, with bus read-back for arbitration.
// PARAMETERS
//  WIDTH       8      pin count, 1..32
//  SYNC_STAGES 2      input synchroniser flops, 2..4
//  OPEN_DRAIN  0      0 push-pull; 1 drive low only, release to Z for a 1
//  EDGE_TYPE   0      0 rising, 1 falling, 2 any edge
//  RESET_OUT   0      reset value of data_out[WIDTH-1:0]
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      reset, asynchronous, active-low
//  address     in   3      register word address
//  chipselect  in   1      slave select
//  write_n     in   1      write strobe, active-low
//  writedata   in   32     write data; bits above WIDTH-1 ignored
//  readdata    out  32     registered read data; bits above WIDTH-1 read 0
//  irq         out  1      level interrupt, active-high
//  bidir_port  inout WIDTH external pins
// BEHAVIOUR
//  Map: 0 DATA (rd synced pins / wr data_out), 1 DIR (rw, 1=output), 2 IRQMASK (rw),
//       3 EDGECAP (rd; wr 1 clears bit), 4 OUTSET, 5 OUTCLR (opt); other addresses read 0, writes ignored.
//  Reset: data_out=RESET_OUT, dir=0, irqmask=0, edgecap=0, readdata=0, sync/prev=0, armed=0, irq=0.
//  Reset is asynchronous and immediate: dir=0 releases all pins to Z in the same instant.
//  Writes: take effect on the clk edge where chipselect & ~write_n; no wait states.
//  Reads: readdata is updated every clk from address, independent of chipselect.
//   Read latency is 1 clk.
//  Drive (push-pull): pin[i] = dir[i] ? data_out[i] : Z.
//  Drive (open-drain): pin[i] = (dir[i] & ~data_out[i]) ? 0 : Z.
//  DATA read returns the synchronised pin value, never data_out (read-back of the actual bus).
//  Input path: SYNC_STAGES-deep chain feeds sync[]; prev[] <= sync[] each clk.
//   rise = sync & ~prev; fall = ~sync & prev; edge = the set chosen by EDGE_TYPE.
//  Arming: 3-bit counter from reset; edge detection is suppressed until SYNC_STAGES+1 clks have elapsed.
//   This prevents spurious captures from pins already high at reset.
//  EDGECAP: edgecap[i] <= (edgecap[i] & ~clr[i]) | (armed & edge[i]).
//   A same-cycle edge and write-1-clear leaves the bit set (set wins).
//  irq = |(edgecap & irqmask), combinational from registers.
//  Edges are captured regardless of dir and irqmask; output-driven pins also capture their own edges.
//  Edge-to-EDGECAP latency: SYNC_STAGES+1 clks after the pin transition.
// CONFIGURATION
//  BIDIR_PIO_OUTSETCLR_EN defined:
//   addr 4 write: data_out |= wd; addr 5 write: data_out &= ~wd (atomic per-bit updates).
//   Both addresses read 0.
//  Not defined: addresses 4/5 behave as unmapped (writes ignored, read 0); no set/clear logic is built.
// STRUCTURE
//  Package bidir_pio_pkg: ADDR_DATA..ADDR_OUTCLR constants, EDGE_RISE/FALL/ANY encodings, MAX_WIDTH=32.
//  Sub-module bidir_pio_sync: WIDTH x SYNC_STAGES synchroniser chain, async reset to 0.
//  One instance of bidir_pio_sync is used; all other logic stays in this module.
// TESTING
//  1 Reset: hold reset_n=0, pins pulled high.
//    -> bidir_port all Z, readdata=0, irq=0.
//    -> After release, EDGECAP reads 0 (arming suppresses the edge).
//  2 WIDTH=8 push-pull: write DIR=0xFF, DATA=0xA5.
//    -> pins=0xA5; DATA read returns 0xA5 after SYNC_STAGES+1 clks, readdata valid 1 clk after address.
//  3 OPEN_DRAIN=1: DIR=0x01, DATA=0x00 -> pin0=0. DATA=0x01 -> pin0=Z.
//    -> With the external driver pulling pin0 low, DATA read bit0=0.
//  4 EDGE_TYPE=0, IRQMASK=0x04: pin2 0->1.
//    -> EDGECAP=0x04 and irq=1 at SYNC_STAGES+1 clks after the transition.
//    -> Write EDGECAP=0x04 -> irq=0 next clk.
//  5 Same-cycle pin2 rise and EDGECAP clear write.
//    -> EDGECAP bit2 stays 1, irq stays 1.
//  6 BIDIR_PIO_OUTSETCLR_EN defined: DATA=0x0F; OUTSET=0x30; OUTCLR=0x01.
//    -> data_out=0x3E. Without the macro, data_out stays 0x0F.

Source files
------------

// File: rtl/bidir_pio_pkg.sv
// Shared constants for the bidirectional PIO: register word map and edge-select encodings.
package bidir_pio_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/bidir_pio_sync.sv
// WIDTH x STAGES input synchroniser chain; every stage resets asynchronously to 0.
module bidir_pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_r;

  // shift raw pin samples through the chain, stage 0 first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/bidir_pio_ctrl.sv
// Avalon-MM bidirectional PIO with per-bit direction, edge capture and maskable level IRQ.
// Define BIDIR_PIO_OUTSETCLR_EN to build the atomic OUTSET/OUTCLR registers at addresses 4/5.
module bidir_pio_ctrl
  import bidir_pio_pkg::*;
#(
  parameter int                   WIDTH       = 8,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   OPEN_DRAIN  = 0,
  parameter int                   EDGE_TYPE   = 0,
  parameter logic [MAX_WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  // edges are ignored until the synchroniser and prev[] hold real pin samples
  localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [WIDTH-1:0] prev_r;
  logic [2:0]       arm_cnt_r;
  logic [31:0]      readdata_r;

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] wd_s;
  logic [31:0]      rd_mux_s;
  logic             wr_en_s;
  logic             armed_s;
  logic             unused_s;

  assign wd_s     = writedata[WIDTH-1:0];
  assign unused_s = ^writedata;
  assign wr_en_s  = chipselect & ~write_n;
  assign armed_s  = (arm_cnt_r == ARM_COUNT);

  bidir_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bidir_port),
    .q       (sync_s)
  );

  // pin drivers: open-drain only ever pulls low, push-pull drives both levels
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    if (OPEN_DRAIN != 0) begin : g_od
      assign bidir_port[i] = (dir_r[i] & ~data_out_r[i]) ? 1'b0 : 1'bz;
    end else begin : g_pp
      assign bidir_port[i] = dir_r[i] ? data_out_r[i] : 1'bz;
    end
  end

  // edge set selected by EDGE_TYPE
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edge_s = sync_s & ~prev_r;
      EDGE_FALL: edge_s = ~sync_s & prev_r;
      EDGE_ANY:  edge_s = sync_s ^ prev_r;
      default:   edge_s = '0;
    endcase
  end

  // write-1-to-clear mask for EDGECAP
  always_comb begin
    if (wr_en_s && (address == ADDR_EDGECAP)) begin
      clr_s = wd_s;
    end else begin
      clr_s = '0;
    end
  end

  // read mux; DATA returns the synchronised bus, not data_out
  always_comb begin
    rd_mux_s = '0;
    case (address)
      ADDR_DATA:    rd_mux_s[WIDTH-1:0] = sync_s;
      ADDR_DIR:     rd_mux_s[WIDTH-1:0] = dir_r;
      ADDR_IRQMASK: rd_mux_s[WIDTH-1:0] = irqmask_r;
      ADDR_EDGECAP: rd_mux_s[WIDTH-1:0] = edgecap_r;
      default:      rd_mux_s = '0;
    endcase
  end

  // register file, arming counter, edge capture and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= RESET_OUT[WIDTH-1:0];
      dir_r      <= '0;
      irqmask_r  <= '0;
      edgecap_r  <= '0;
      prev_r     <= '0;
      arm_cnt_r  <= 3'd0;
      readdata_r <= 32'd0;
    end else begin
      prev_r     <= sync_s;
      readdata_r <= rd_mux_s;
      if (!armed_s) begin
        arm_cnt_r <= arm_cnt_r + 3'd1;
      end
      // a capture in the same cycle as a clear wins
      edgecap_r <= (edgecap_r & ~clr_s) | (edge_s & {WIDTH{armed_s}});
      if (wr_en_s) begin
        case (address)
          ADDR_DATA:    data_out_r <= wd_s;
          ADDR_DIR:     dir_r      <= wd_s;
          ADDR_IRQMASK: irqmask_r  <= wd_s;
`ifdef BIDIR_PIO_OUTSETCLR_EN
          ADDR_OUTSET:  data_out_r <= data_out_r | wd_s;
          ADDR_OUTCLR:  data_out_r <= data_out_r & ~wd_s;
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign readdata = readdata_r;
  assign irq      = |(edgecap_r & irqmask_r);

endmodule
